// File: rtl/host_loader_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the host command loader.
package host_loader_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned ADDR_W_DEF  = 13;
  localparam int unsigned MAX_LEN_DEF = 16;

  localparam logic [7:0] OP_WR_WEIGHT = 8'h01;
  localparam logic [7:0] OP_WR_INPUT  = 8'h02;
  localparam logic [7:0] OP_RUN       = 8'h03;
  localparam logic [7:0] OP_RD_RESULT = 8'h04;

  typedef enum logic [3:0] {
    StIdle,
    StAddrHi,
    StAddrLo,
    StLen,
    StPayload,
`ifdef HOST_LOADER_CHECKSUM_EN
    StCsum,
`endif
    StRunWait,
    StReadReq,
    StReadData,
    StReadSend
  } state_e;

endpackage

// File: rtl/host_loader_if.sv
// Host byte stream, memory write/read ports, tpu control and result stream of the loader.
interface host_loader_if
  import host_loader_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              wm_we;
  logic [ADDR_W-1:0] wm_addr;
  logic [DATA_W-1:0] wm_wdata;
  logic              ub_we;
  logic [ADDR_W-1:0] ub_addr;
  logic [DATA_W-1:0] ub_wdata;
  logic              ub_rd_en;
  logic [ADDR_W-1:0] ub_rd_addr;
  logic [DATA_W-1:0] ub_rd_data;
  logic              start;
  logic              tpu_done;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              busy;
  logic              err;

  // Host / tpu environment side.
  modport master (
    output s_valid, s_data, ub_rd_data, tpu_done, m_ready,
    input  s_ready, wm_we, wm_addr, wm_wdata, ub_we, ub_addr, ub_wdata,
    input  ub_rd_en, ub_rd_addr, start, m_valid, m_data, busy, err
  );

  // Loader side.
  modport slave (
    input  s_valid, s_data, ub_rd_data, tpu_done, m_ready,
    output s_ready, wm_we, wm_addr, wm_wdata, ub_we, ub_addr, ub_wdata,
    output ub_rd_en, ub_rd_addr, start, m_valid, m_data, busy, err
  );
endinterface

// File: rtl/host_loader.sv
// Byte-stream command decoder feeding tpu memories, start pulse and result readback.
// Define HOST_LOADER_CHECKSUM_EN to add XOR checksum bytes to write and read commands.
module host_loader
  import host_loader_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
  input  logic          clk,
  input  logic          reset,
  host_loader_if.slave  io_bus
);

  state_e            r_state;
  logic [7:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_len;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_wm_we;
  logic              r_ub_we;
  logic              r_start;
  logic              r_err;
  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
`ifdef HOST_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
`endif

  logic w_rdy_st;
  logic w_s_fire;
  logic w_len_bad;

  always_comb begin
    w_rdy_st = 1'b0;
    case (r_state)
      StIdle, StAddrHi, StAddrLo, StLen, StPayload: w_rdy_st = 1'b1;
`ifdef HOST_LOADER_CHECKSUM_EN
      StCsum: w_rdy_st = 1'b1;
`endif
      default: w_rdy_st = 1'b0;
    endcase
  end

  assign w_s_fire  = io_bus.s_valid && w_rdy_st;
  assign w_len_bad = (io_bus.s_data == '0) || (32'(io_bus.s_data) > MAX_LEN);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_op      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wm_we   <= 1'b0;
      r_ub_we   <= 1'b0;
      r_start   <= 1'b0;
      r_err     <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
`ifdef HOST_LOADER_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      r_wm_we <= 1'b0;
      r_ub_we <= 1'b0;
      r_start <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_s_fire) begin
`ifdef HOST_LOADER_CHECKSUM_EN
            r_csum <= '0;
`endif
            case (io_bus.s_data[7:0])
              OP_WR_WEIGHT, OP_WR_INPUT, OP_RD_RESULT: begin
                r_op    <= io_bus.s_data[7:0];
                r_state <= StAddrHi;
              end
              OP_RUN: begin
                r_start <= 1'b1;
                r_state <= StRunWait;
              end
              default: r_err <= 1'b1;
            endcase
          end
        end
        StAddrHi: begin
          if (w_s_fire) begin
            r_addr  <= {io_bus.s_data[ADDR_W-9:0], r_addr[7:0]};
            r_state <= StAddrLo;
          end
        end
        StAddrLo: begin
          if (w_s_fire) begin
            r_addr  <= {r_addr[ADDR_W-1:8], io_bus.s_data[7:0]};
            r_state <= StLen;
          end
        end
        StLen: begin
          if (w_s_fire) begin
            if (w_len_bad) begin
              r_err   <= 1'b1;
              r_state <= StIdle;
            end else begin
              r_len   <= io_bus.s_data;
              r_state <= (r_op == OP_RD_RESULT) ? StReadReq : StPayload;
            end
          end
        end
        StPayload: begin
          if (w_s_fire) begin
            r_wm_we   <= (r_op == OP_WR_WEIGHT);
            r_ub_we   <= (r_op == OP_WR_INPUT);
            r_wr_addr <= r_addr;
            r_wr_data <= io_bus.s_data;
            r_addr    <= r_addr + ADDR_W'(1);
            r_len     <= r_len - DATA_W'(1);
`ifdef HOST_LOADER_CHECKSUM_EN
            r_csum    <= r_csum ^ io_bus.s_data;
            if (r_len == DATA_W'(1)) r_state <= StCsum;
`else
            if (r_len == DATA_W'(1)) r_state <= StIdle;
`endif
          end
        end
`ifdef HOST_LOADER_CHECKSUM_EN
        StCsum: begin
          if (w_s_fire) begin
            if (io_bus.s_data != r_csum) r_err <= 1'b1;
            r_state <= StIdle;
          end
        end
`endif
        StRunWait: begin
          // tpu_done is ignored during the start cycle itself.
          if (!r_start && io_bus.tpu_done) r_state <= StIdle;
        end
        StReadReq: r_state <= StReadData;
        StReadData: begin
          r_m_data  <= io_bus.ub_rd_data;
          r_m_valid <= 1'b1;
          r_state   <= StReadSend;
        end
        StReadSend: begin
          if (io_bus.m_ready) begin
`ifdef HOST_LOADER_CHECKSUM_EN
            // r_len reaching zero marks the trailing checksum byte.
            if (r_len == '0) begin
              r_m_valid <= 1'b0;
              r_state   <= StIdle;
            end else begin
              r_csum <= r_csum ^ r_m_data;
              r_addr <= r_addr + ADDR_W'(1);
              r_len  <= r_len - DATA_W'(1);
              if (r_len == DATA_W'(1)) begin
                r_m_data <= r_csum ^ r_m_data;
              end else begin
                r_m_valid <= 1'b0;
                r_state   <= StReadReq;
              end
            end
`else
            r_m_valid <= 1'b0;
            r_addr    <= r_addr + ADDR_W'(1);
            r_len     <= r_len - DATA_W'(1);
            r_state   <= (r_len == DATA_W'(1)) ? StIdle : StReadReq;
`endif
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Outputs are forced low for as long as reset is held.
  assign io_bus.s_ready    = reset & w_rdy_st;
  assign io_bus.wm_we      = reset & r_wm_we;
  assign io_bus.wm_addr    = {ADDR_W{reset}} & r_wr_addr;
  assign io_bus.wm_wdata   = {DATA_W{reset}} & r_wr_data;
  assign io_bus.ub_we      = reset & r_ub_we;
  assign io_bus.ub_addr    = {ADDR_W{reset}} & r_wr_addr;
  assign io_bus.ub_wdata   = {DATA_W{reset}} & r_wr_data;
  assign io_bus.ub_rd_en   = reset & (r_state == StReadReq);
  assign io_bus.ub_rd_addr = {ADDR_W{reset}} & r_addr;
  assign io_bus.start      = reset & r_start;
  assign io_bus.m_valid    = reset & r_m_valid;
  assign io_bus.m_data     = {DATA_W{reset}} & r_m_data;
  assign io_bus.busy       = reset & (r_state != StIdle);
  assign io_bus.err        = reset & r_err;

endmodule
